// File: rtl/reg_write_port_if.sv
// Write-request channel into the register bank write port.
//   wr_valid : source has a request on wr_addr / wr_data
//   wr_ready : write port can take a request this cycle
//   wr_addr  : destination register index, 0..31
//   wr_data  : data to be written
// master = request source, slave = reg_write_port.
interface reg_write_port_if #(
  parameter int WIDTH = 32
);
  logic             wr_valid;
  logic             wr_ready;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/reg_write_port.sv
// Write side of the 32 x WIDTH register file.
// Requests arrive on a valid/ready channel and are held in a 2-entry
// in-order buffer. While the buffer is non-empty, one entry per cycle is
// committed into the bank through a one-hot enable. The bank drives the
// read-mux inputs on q[0..31].
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset, synchronous release
//   wr     : write-request channel (slave side)
//   clr    : synchronous clear of the bank and flush of the buffer
//   wr_en  : one-hot commit enable, bit k high in the cycle register k is written
//   busy   : a buffered write is pending
//   q      : current register contents
module reg_write_port #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_write_port_if.slave  wr,
  input  logic             clr,
  output logic [31:0]      wr_en,
  output logic             busy,
  output logic [WIDTH-1:0] q [32]
);

  function automatic logic [31:0] decode_onehot(input logic [4:0] addr);
    logic [31:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

  logic [4:0]       buf_addr [2];
  logic [WIDTH-1:0] buf_data [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic             push;
  logic             pop;
  logic             commit_ok;
  logic [4:0]       head_addr;
  logic [WIDTH-1:0] head_data;

  // Ready looks only at the registered count; a same-cycle pop does not
  // open a slot.
  assign wr.wr_ready = (count < 2'd2) && !clr;
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop         = (count != 2'd0) && !clr;
  assign busy        = (count != 2'd0);

  assign head_addr = buf_addr[rd_ptr];
  assign head_data = buf_data[rd_ptr];

  // A write to register 0 with ZERO_REG set still consumes its commit
  // slot; it simply produces no enable.
  assign commit_ok = pop && !(ZERO_REG && (head_addr == 5'd0));
  assign wr_en     = commit_ok ? decode_onehot(head_addr) : 32'd0;

  // Buffer control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (clr) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; entries are only meaningful while counted, so they
  // carry no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= wr.wr_addr;
      buf_data[wr_ptr] <= wr.wr_data;
    end
  end

  // Register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) q[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < 32; k++) q[k] <= '0;
    end else begin
      for (int k = 0; k < 32; k++) begin
        if (wr_en[k]) q[k] <= head_data;
      end
    end
  end

endmodule
